reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_if.sv | 38 +++
 rtl/reg_file.sv | 88 ++++++++
 tb/tb_reg_file.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Bundle of commit, issue and operand-read signals between the pipeline and the
// architectural register file.
interface reg_file_if #(
    parameter int REG_NUM_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 5
);
    logic                      rob_valid;
    logic [REG_NUM_WIDTH-1:0]  rob_rd;
    logic [31:0]               rob_value;
    logic [ROB_SIZE_WIDTH-1:0] rob_dependency;

    logic                      dec_valid;
    logic [REG_NUM_WIDTH-1:0]  dec_rd;
    logic [ROB_SIZE_WIDTH-1:0] dec_rob_id;
    logic [REG_NUM_WIDTH-1:0]  dec_rs1;
    logic [REG_NUM_WIDTH-1:0]  dec_rs2;

    logic [31:0]               rs1_value;
    logic [31:0]               rs2_value;
    logic                      rs1_busy;
    logic                      rs2_busy;
    logic [ROB_SIZE_WIDTH-1:0] rs1_dependency;
    logic [ROB_SIZE_WIDTH-1:0] rs2_dependency;

    modport master (
        output rob_valid, rob_rd, rob_value, rob_dependency,
        output dec_valid, dec_rd, dec_rob_id, dec_rs1, dec_rs2,
        input  rs1_value, rs2_value, rs1_busy, rs2_busy,
        input  rs1_dependency, rs2_dependency
    );

    modport slave (
        input  rob_valid, rob_rd, rob_value, rob_dependency,
        input  dec_valid, dec_rd, dec_rob_id, dec_rs1, dec_rs2,
        output rs1_value, rs2_value, rs1_busy, rs2_busy,
        output rs1_dependency, rs2_dependency
    );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with rename tags: holds committed values, a busy bit
// and producing ROB tag per register, with commit-to-read bypass on both read ports.
module reg_file #(
    parameter int REG_NUM_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 5
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     flush_in,
    reg_file_if.slave rf
);
    localparam int REG_COUNT = 1 << REG_NUM_WIDTH;

    logic [31:0]               r_value [REG_COUNT];
    logic                      r_busy  [REG_COUNT];
    logic [ROB_SIZE_WIDTH-1:0] r_tag   [REG_COUNT];

    logic                      w_commit;
    logic                      w_commit_hit;
    logic                      w_issue;
    logic [REG_NUM_WIDTH-1:0]  w_rs  [2];
    logic [31:0]               w_val [2];
    logic                      w_bsy [2];
    logic [ROB_SIZE_WIDTH-1:0] w_dep [2];

    assign w_commit     = rf.rob_valid && (rf.rob_rd != {REG_NUM_WIDTH{1'b0}});
    assign w_commit_hit = w_commit && r_busy[rf.rob_rd] && (r_tag[rf.rob_rd] == rf.rob_dependency);
    assign w_issue      = rf.dec_valid && (rf.dec_rd != {REG_NUM_WIDTH{1'b0}}) && !flush_in;

    // State update: commit first, then flush clears every busy bit, else issue overrides.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_value[i] <= 32'd0;
                r_busy[i]  <= 1'b0;
                r_tag[i]   <= {ROB_SIZE_WIDTH{1'b0}};
            end
        end else if (rdy_in) begin
            if (w_commit) begin
                r_value[rf.rob_rd] <= rf.rob_value;
            end
            if (w_commit_hit) begin
                r_busy[rf.rob_rd] <= 1'b0;
            end
            if (flush_in) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    r_busy[i] <= 1'b0;
                end
            end else if (w_issue) begin
                r_busy[rf.dec_rd] <= 1'b1;
                r_tag[rf.dec_rd]  <= rf.dec_rob_id;
            end
        end
    end

    assign w_rs[0] = rf.dec_rs1;
    assign w_rs[1] = rf.dec_rs2;

    // Operand reads; a matching commit in the same cycle is forwarded, x0 is hard zero.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_val[p] = 32'd0;
            w_bsy[p] = 1'b0;
            w_dep[p] = {ROB_SIZE_WIDTH{1'b0}};
            if (w_rs[p] == {REG_NUM_WIDTH{1'b0}}) begin
                w_val[p] = 32'd0;
                w_bsy[p] = 1'b0;
                w_dep[p] = {ROB_SIZE_WIDTH{1'b0}};
            end else if (w_commit_hit && (rf.rob_rd == w_rs[p])) begin
                w_val[p] = rf.rob_value;
                w_bsy[p] = 1'b0;
                w_dep[p] = r_tag[w_rs[p]];
            end else begin
                w_val[p] = r_value[w_rs[p]];
                w_bsy[p] = r_busy[w_rs[p]];
                w_dep[p] = r_tag[w_rs[p]];
            end
        end
    end

    assign rf.rs1_value      = w_val[0];
    assign rf.rs1_busy       = w_bsy[0];
    assign rf.rs1_dependency = w_dep[0];
    assign rf.rs2_value      = w_val[1];
    assign rf.rs2_busy       = w_bsy[1];
    assign rf.rs2_dependency = w_dep[1];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based model of register values, busy bits and tags.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    reg_file_if #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(5)) bus ();

    reg_file #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(5)) dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .rdy_in  (rdy),
        .flush_in(flush),
        .rf      (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [4:0]  m_tag  [32];

    task automatic idle_inputs();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        bus.rob_valid = 1'b0; bus.rob_rd = 5'd0; bus.rob_value = 32'd0; bus.rob_dependency = 5'd0;
        bus.dec_valid = 1'b0; bus.dec_rd = 5'd0; bus.dec_rob_id = 5'd0;
        bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0;
    endtask

    // Model of one clock edge, applied from the currently driven inputs.
    task automatic model_edge();
        int  rd;
        int  ird;
        bit  cmatch;
        rd  = int'(bus.rob_rd);
        ird = int'(bus.dec_rd);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 5'd0;
            end
        end else if (rdy) begin
            cmatch = bus.rob_valid && rd != 0 && m_busy[rd] && m_tag[rd] == bus.rob_dependency;
            if (bus.rob_valid && rd != 0) m_val[rd] = bus.rob_value;
            if (cmatch) m_busy[rd] = 1'b0;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (bus.dec_valid && ird != 0) begin
                m_busy[ird] = 1'b1;
                m_tag[ird]  = bus.dec_rob_id;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // What a read of register rs should show given model state and current commit.
    function automatic void exp_read(input logic [4:0] rs, output logic [31:0] v,
                                     output logic b, output logic [4:0] d);
        int r;
        r = int'(rs);
        v = m_val[r]; b = m_busy[r]; d = m_tag[r];
        if (r == 0) begin
            v = 32'd0; b = 1'b0; d = 5'd0;
        end else if (bus.rob_valid && bus.rob_rd == rs && m_busy[r] && m_tag[r] == bus.rob_dependency) begin
            v = bus.rob_value; b = 1'b0;
        end
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        bus.dec_rs1 = 5'd5; bus.dec_rs2 = 5'd31;
        #1;
        checks++;
        if (bus.rs1_value !== 32'd0 || bus.rs1_busy !== 1'b0 || bus.rs2_value !== 32'd0 || bus.rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_x5_x31: got rs1=%h/%b rs2=%h/%b, want 0/0 0/0",
                     bus.rs1_value, bus.rs1_busy, bus.rs2_value, bus.rs2_busy);
        end
        for (int i = 0; i < 32; i++) begin
            bus.dec_rs1 = 5'(i); bus.dec_rs2 = 5'(31 - i);
            #1;
            checks++;
            if ({bus.rs1_value, bus.rs1_busy, bus.rs1_dependency, bus.rs2_value, bus.rs2_busy, bus.rs2_dependency} !== 76'd0) begin
                errors++;
                $display("FAIL reset_all r%0d: got %h/%b/%0d %h/%b/%0d, want all zero", i,
                         bus.rs1_value, bus.rs1_busy, bus.rs1_dependency, bus.rs2_value, bus.rs2_busy, bus.rs2_dependency);
            end
        end
    endtask

    task automatic test_issue_commit();
        idle_inputs();
        bus.dec_valid = 1'b1; bus.dec_rd = 5'd3; bus.dec_rob_id = 5'd7;
        step();
        idle_inputs();
        bus.dec_rs1 = 5'd3;
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b1 || bus.rs1_dependency !== 5'd7) begin
            errors++;
            $display("FAIL issue_busy: got busy=%b dep=%0d, want 1/7", bus.rs1_busy, bus.rs1_dependency);
        end
        bus.rob_valid = 1'b1; bus.rob_rd = 5'd3; bus.rob_dependency = 5'd7; bus.rob_value = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.rs1_value !== 32'hDEAD_BEEF || bus.rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL commit_bypass: got %h/%b, want deadbeef/0", bus.rs1_value, bus.rs1_busy);
        end
        step();
        bus.rob_valid = 1'b0;
        #1;
        checks++;
        if (bus.rs1_value !== 32'hDEAD_BEEF || bus.rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL commit_registered: got %h/%b, want deadbeef/0", bus.rs1_value, bus.rs1_busy);
        end
    endtask

    task automatic test_stale_tag();
        idle_inputs();
        bus.dec_valid = 1'b1; bus.dec_rd = 5'd4; bus.dec_rob_id = 5'd2;
        step();
        bus.dec_rob_id = 5'd9;
        step();
        idle_inputs();
        bus.rob_valid = 1'b1; bus.rob_rd = 5'd4; bus.rob_dependency = 5'd2; bus.rob_value = 32'h11;
        bus.dec_rs2 = 5'd4;
        #1;
        checks++;
        if (bus.rs2_busy !== 1'b1 || bus.rs2_dependency !== 5'd9 || bus.rs2_value !== 32'd0) begin
            errors++;
            $display("FAIL stale_same_cycle: got %h/%b/%0d, want 0/1/9", bus.rs2_value, bus.rs2_busy, bus.rs2_dependency);
        end
        step();
        bus.rob_valid = 1'b0;
        #1;
        checks++;
        if (bus.rs2_busy !== 1'b1 || bus.rs2_dependency !== 5'd9 || bus.rs2_value !== 32'h11) begin
            errors++;
            $display("FAIL stale_after: got %h/%b/%0d, want 11/1/9", bus.rs2_value, bus.rs2_busy, bus.rs2_dependency);
        end
    endtask

    task automatic test_commit_issue_same();
        idle_inputs();
        bus.dec_valid = 1'b1; bus.dec_rd = 5'd6; bus.dec_rob_id = 5'd1;
        step();
        bus.dec_rob_id = 5'd12;
        bus.rob_valid = 1'b1; bus.rob_rd = 5'd6; bus.rob_dependency = 5'd1; bus.rob_value = 32'hA5A5_0006;
        step();
        idle_inputs();
        bus.dec_rs1 = 5'd6;
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b1 || bus.rs1_dependency !== 5'd12 || bus.rs1_value !== 32'hA5A5_0006) begin
            errors++;
            $display("FAIL issue_wins: got %h/%b/%0d, want a5a50006/1/12", bus.rs1_value, bus.rs1_busy, bus.rs1_dependency);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int r = 1; r <= 3; r++) begin
            bus.dec_valid = 1'b1; bus.dec_rd = 5'(r); bus.dec_rob_id = 5'(r + 2);
            step();
        end
        idle_inputs();
        flush = 1'b1;
        bus.rob_valid = 1'b1; bus.rob_rd = 5'd1; bus.rob_dependency = 5'd0; bus.rob_value = 32'h40;
        bus.dec_valid = 1'b1; bus.dec_rd = 5'd5; bus.dec_rob_id = 5'd9;
        step();
        idle_inputs();
        bus.dec_rs1 = 5'd1; bus.dec_rs2 = 5'd2;
        #1;
        checks++;
        if (bus.rs1_value !== 32'h40 || bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_x1_x2: got x1=%h/%b x2 busy=%b, want 40/0 0", bus.rs1_value, bus.rs1_busy, bus.rs2_busy);
        end
        bus.dec_rs1 = 5'd3; bus.dec_rs2 = 5'd5;
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_x3_x5: got x3 busy=%b x5 busy=%b, want 0 0", bus.rs1_busy, bus.rs2_busy);
        end
    endtask

    task automatic test_x0_and_rdy();
        idle_inputs();
        bus.dec_valid = 1'b1; bus.dec_rd = 5'd0; bus.dec_rob_id = 5'd4;
        bus.rob_valid = 1'b1; bus.rob_rd = 5'd0; bus.rob_value = 32'h55;
        step();
        idle_inputs();
        #1;
        checks++;
        if (bus.rs1_value !== 32'd0 || bus.rs1_busy !== 1'b0 || bus.rs1_dependency !== 5'd0) begin
            errors++;
            $display("FAIL x0_write: got %h/%b/%0d, want 0/0/0", bus.rs1_value, bus.rs1_busy, bus.rs1_dependency);
        end
        rdy = 1'b0;
        bus.dec_valid = 1'b1; bus.dec_rd = 5'd7; bus.dec_rob_id = 5'd3;
        bus.rob_valid = 1'b1; bus.rob_rd = 5'd8; bus.rob_value = 32'h77;
        step();
        idle_inputs();
        bus.dec_rs1 = 5'd7; bus.dec_rs2 = 5'd8;
        #1;
        checks++;
        if (bus.rs1_busy !== 1'b0 || bus.rs2_value !== 32'd0) begin
            errors++;
            $display("FAIL rdy_hold: got x7 busy=%b x8=%h, want 0 0", bus.rs1_busy, bus.rs2_value);
        end
    endtask

    task automatic test_random();
        logic [31:0] ev;
        logic        eb;
        logic [4:0]  ed;
        idle_inputs();
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            rdy   = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 15) == 0);
            bus.rob_valid = $urandom_range(0, 1) == 1;
            bus.rob_rd    = 5'($urandom_range(0, 7));
            bus.rob_value = $urandom;
            bus.rob_dependency = ($urandom_range(0, 2) != 0) ? m_tag[bus.rob_rd] : 5'($urandom_range(0, 31));
            bus.dec_valid  = $urandom_range(0, 1) == 1;
            bus.dec_rd     = 5'($urandom_range(0, 7));
            bus.dec_rob_id = 5'($urandom_range(0, 31));
            bus.dec_rs1    = ($urandom_range(0, 1) == 1) ? bus.rob_rd : 5'($urandom_range(0, 7));
            bus.dec_rs2    = 5'($urandom_range(0, 31));
            #1;
            exp_read(bus.dec_rs1, ev, eb, ed);
            checks++;
            if (bus.rs1_value !== ev || bus.rs1_busy !== eb || (eb && bus.rs1_dependency !== ed)) begin
                errors++;
                $display("FAIL rand_rs1 n=%0d r%0d: got %h/%b/%0d, want %h/%b/%0d", n, bus.dec_rs1,
                         bus.rs1_value, bus.rs1_busy, bus.rs1_dependency, ev, eb, ed);
            end
            exp_read(bus.dec_rs2, ev, eb, ed);
            checks++;
            if (bus.rs2_value !== ev || bus.rs2_busy !== eb || (eb && bus.rs2_dependency !== ed)) begin
                errors++;
                $display("FAIL rand_rs2 n=%0d r%0d: got %h/%b/%0d, want %h/%b/%0d", n, bus.dec_rs2,
                         bus.rs2_value, bus.rs2_busy, bus.rs2_dependency, ev, eb, ed);
            end
            step();
        end
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_issue_commit();
        test_stale_tag();
        test_commit_issue_same();
        test_flush();
        test_x0_and_rdy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
